// File: rtl/hilo_regfile.sv
// HI/LO architectural register block: carries multiply/divide and mthi/mtlo
// results through the M and W stages, commits at the end of W, and forwards to E.
module hilo_regfile #(
    parameter logic [31:0] RESET_HI = 32'h0000_0000,
    parameter logic [31:0] RESET_LO = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush_e,
    input  logic        flush_m,
    input  logic        e_hi_we,
    input  logic        e_lo_we,
    input  logic [31:0] e_hi,
    input  logic [31:0] e_lo,
    output logic [31:0] hi_fwd,
    output logic [31:0] lo_fwd,
    output logic [31:0] hi_arch,
    output logic [31:0] lo_arch,
    output logic        pending
);

    logic        m_hi_we_r;
    logic        m_lo_we_r;
    logic [31:0] m_hi_r;
    logic [31:0] m_lo_r;
    logic        w_hi_we_r;
    logic        w_lo_we_r;
    logic [31:0] w_hi_r;
    logic [31:0] w_lo_r;
    logic [31:0] hi_q_r;
    logic [31:0] lo_q_r;
    logic [31:0] hi_fwd_s;
    logic [31:0] lo_fwd_s;

    // M stage entry: captures E, holds on stall, but an M flush always kills it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi_we_r <= 1'b0;
            m_lo_we_r <= 1'b0;
            m_hi_r    <= 32'h0000_0000;
            m_lo_r    <= 32'h0000_0000;
        end else if (stall) begin
            if (flush_m) begin
                m_hi_we_r <= 1'b0;
                m_lo_we_r <= 1'b0;
            end else begin
                m_hi_we_r <= m_hi_we_r;
                m_lo_we_r <= m_lo_we_r;
            end
        end else begin
            m_hi_we_r <= e_hi_we & ~flush_e;
            m_lo_we_r <= e_lo_we & ~flush_e;
            m_hi_r    <= e_hi;
            m_lo_r    <= e_lo;
        end
    end

    // W stage entry: takes M unless stalled; a flushed M entry arrives without enables
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_hi_we_r <= 1'b0;
            w_lo_we_r <= 1'b0;
            w_hi_r    <= 32'h0000_0000;
            w_lo_r    <= 32'h0000_0000;
        end else if (!stall) begin
            w_hi_we_r <= m_hi_we_r & ~flush_m;
            w_lo_we_r <= m_lo_we_r & ~flush_m;
            w_hi_r    <= m_hi_r;
            w_lo_r    <= m_lo_r;
        end else begin
            w_hi_we_r <= w_hi_we_r;
            w_lo_we_r <= w_lo_we_r;
        end
    end

    // Architectural HI/LO commit; each half commits on its own enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q_r <= RESET_HI;
            lo_q_r <= RESET_LO;
        end else if (!stall) begin
            if (w_hi_we_r) begin
                hi_q_r <= w_hi_r;
            end else begin
                hi_q_r <= hi_q_r;
            end
            if (w_lo_we_r) begin
                lo_q_r <= w_lo_r;
            end else begin
                lo_q_r <= lo_q_r;
            end
        end else begin
            hi_q_r <= hi_q_r;
            lo_q_r <= lo_q_r;
        end
    end

    // Forwarding to E: youngest pending write (M, then W) wins, else committed value
    always_comb begin
        hi_fwd_s = hi_q_r;
        lo_fwd_s = lo_q_r;
        if (m_hi_we_r) begin
            hi_fwd_s = m_hi_r;
        end else if (w_hi_we_r) begin
            hi_fwd_s = w_hi_r;
        end else begin
            hi_fwd_s = hi_q_r;
        end
        if (m_lo_we_r) begin
            lo_fwd_s = m_lo_r;
        end else if (w_lo_we_r) begin
            lo_fwd_s = w_lo_r;
        end else begin
            lo_fwd_s = lo_q_r;
        end
    end

    assign hi_fwd  = hi_fwd_s;
    assign lo_fwd  = lo_fwd_s;
    assign hi_arch = hi_q_r;
    assign lo_arch = lo_q_r;
    assign pending = m_hi_we_r | m_lo_we_r | w_hi_we_r | w_lo_we_r;

endmodule

// File: tb/tb_hilo_regfile.sv
// Directed, table-driven bench for hilo_regfile plus an asynchronous reset sequence.
module tb_hilo_regfile;

    localparam logic [31:0] RH = 32'h0BAD_F00D;
    localparam logic [31:0] RL = 32'h0D15_EA5E;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush_e;
    logic        flush_m;
    logic        e_hi_we;
    logic        e_lo_we;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic [31:0] hi_fwd;
    logic [31:0] lo_fwd;
    logic [31:0] hi_arch;
    logic [31:0] lo_arch;
    logic        pending;

    int checks = 0;
    int errors = 0;

    hilo_regfile #(.RESET_HI(RH), .RESET_LO(RL)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush_e(flush_e), .flush_m(flush_m),
        .e_hi_we(e_hi_we), .e_lo_we(e_lo_we), .e_hi(e_hi), .e_lo(e_lo),
        .hi_fwd(hi_fwd), .lo_fwd(lo_fwd), .hi_arch(hi_arch), .lo_arch(lo_arch),
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st, fe, fm, hwe, lwe;
        logic [31:0] hi, lo;
        logic [31:0] xhf, xlf, xha, xla;
        logic        xp;
    } vec_t;

    vec_t vecs [32];

    function automatic vec_t mk(input logic st, input logic fe, input logic fm,
                                input logic hwe, input logic lwe,
                                input logic [31:0] hi, input logic [31:0] lo,
                                input logic [31:0] xhf, input logic [31:0] xlf,
                                input logic [31:0] xha, input logic [31:0] xla,
                                input logic xp);
        vec_t v;
        v.st = st; v.fe = fe; v.fm = fm; v.hwe = hwe; v.lwe = lwe;
        v.hi = hi; v.lo = lo;
        v.xhf = xhf; v.xlf = xlf; v.xha = xha; v.xla = xla; v.xp = xp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] xhf, input logic [31:0] xlf,
                           input logic [31:0] xha, input logic [31:0] xla, input logic xp);
        chk({tag, " hi_fwd"}, hi_fwd, xhf);
        chk({tag, " lo_fwd"}, lo_fwd, xlf);
        chk({tag, " hi_arch"}, hi_arch, xha);
        chk({tag, " lo_arch"}, lo_arch, xla);
        chk({tag, " pending"}, {31'd0, pending}, {31'd0, xp});
    endtask

    task automatic drive(input logic st, input logic fe, input logic fm, input logic hwe,
                         input logic lwe, input logic [31:0] hi, input logic [31:0] lo);
        stall = st; flush_e = fe; flush_m = fm;
        e_hi_we = hwe; e_lo_we = lwe; e_hi = hi; e_lo = lo;
    endtask

    initial begin
        // single write of both halves
        vecs[0]  = mk(1'b0,1'b0,1'b0,1'b1,1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0, RH, RL, 1'b1);
        vecs[1]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'h1234_5678, 32'h9ABC_DEF0, RH, RL, 1'b1);
        vecs[2]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        // back-to-back HI writes
        vecs[3]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0, 32'h1, 32'h0, 32'h1, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        vecs[4]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0, 32'h2, 32'h0, 32'h2, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        vecs[5]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'h2, 32'h9ABC_DEF0, 32'h1, 32'h9ABC_DEF0, 1'b1);
        vecs[6]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'h2, 32'h9ABC_DEF0, 32'h2, 32'h9ABC_DEF0, 1'b0);
        // LO = 5, then mthi with junk on the unwritten LO half
        vecs[7]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h5, 32'h2, 32'h5, 32'h2, 32'h9ABC_DEF0, 1'b1);
        vecs[8]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'h2, 32'h5, 32'h2, 32'h9ABC_DEF0, 1'b1);
        vecs[9]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'h2, 32'h5, 32'h2, 32'h5, 1'b0);
        vecs[10] = mk(1'b0,1'b0,1'b0,1'b1,1'b0, 32'hFFFF_0000, 32'hDEAD_BEEF, 32'hFFFF_0000, 32'h5, 32'h2, 32'h5, 1'b1);
        vecs[11] = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'hFFFF_0000, 32'h5, 32'h2, 32'h5, 1'b1);
        vecs[12] = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'hFFFF_0000, 32'h5, 32'hFFFF_0000, 32'h5, 1'b0);
        // flush_m kills the M entry; flush_e keeps a write out of M
        vecs[13] = mk(1'b0,1'b0,1'b0,1'b1,1'b0, 32'hAAAA_0001, 32'h0, 32'hAAAA_0001, 32'h5, 32'hFFFF_0000, 32'h5, 1'b1);
        vecs[14] = mk(1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0, 32'h0, 32'hFFFF_0000, 32'h5, 32'hFFFF_0000, 32'h5, 1'b0);
        vecs[15] = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'hFFFF_0000, 32'h5, 32'hFFFF_0000, 32'h5, 1'b0);
        vecs[16] = mk(1'b0,1'b1,1'b0,1'b1,1'b0, 32'hBBBB_0002, 32'h0, 32'hFFFF_0000, 32'h5, 32'hFFFF_0000, 32'h5, 1'b0);
        vecs[17] = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'hFFFF_0000, 32'h5, 32'hFFFF_0000, 32'h5, 1'b0);
        // three stalled edges hold M; commit visible at t6
        vecs[18] = mk(1'b0,1'b0,1'b0,1'b1,1'b1, 32'hC0DE_0003, 32'hC0DE_0004, 32'hC0DE_0003, 32'hC0DE_0004, 32'hFFFF_0000, 32'h5, 1'b1);
        vecs[19] = mk(1'b1,1'b0,1'b0,1'b1,1'b1, 32'hDDDD_1111, 32'hDDDD_2222, 32'hC0DE_0003, 32'hC0DE_0004, 32'hFFFF_0000, 32'h5, 1'b1);
        vecs[20] = mk(1'b1,1'b1,1'b0,1'b1,1'b1, 32'hDDDD_1111, 32'hDDDD_2222, 32'hC0DE_0003, 32'hC0DE_0004, 32'hFFFF_0000, 32'h5, 1'b1);
        vecs[21] = mk(1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'hC0DE_0003, 32'hC0DE_0004, 32'hFFFF_0000, 32'h5, 1'b1);
        vecs[22] = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'hC0DE_0003, 32'hC0DE_0004, 32'hFFFF_0000, 32'h5, 1'b1);
        vecs[23] = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'hC0DE_0003, 32'hC0DE_0004, 32'hC0DE_0003, 32'hC0DE_0004, 1'b0);
        // flush_m during stall clears the held M entry
        vecs[24] = mk(1'b0,1'b0,1'b0,1'b1,1'b0, 32'hE000_0005, 32'h0, 32'hE000_0005, 32'hC0DE_0004, 32'hC0DE_0003, 32'hC0DE_0004, 1'b1);
        vecs[25] = mk(1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'hE000_0005, 32'hC0DE_0004, 32'hC0DE_0003, 32'hC0DE_0004, 1'b1);
        vecs[26] = mk(1'b1,1'b0,1'b1,1'b0,1'b0, 32'h0, 32'h0, 32'hC0DE_0003, 32'hC0DE_0004, 32'hC0DE_0003, 32'hC0DE_0004, 1'b0);
        vecs[27] = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'hC0DE_0003, 32'hC0DE_0004, 32'hC0DE_0003, 32'hC0DE_0004, 1'b0);
        // stall with the entry in W delays the commit
        vecs[28] = mk(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, 32'hF0F0_F0F0, 32'hC0DE_0003, 32'hF0F0_F0F0, 32'hC0DE_0003, 32'hC0DE_0004, 1'b1);
        vecs[29] = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'hC0DE_0003, 32'hF0F0_F0F0, 32'hC0DE_0003, 32'hC0DE_0004, 1'b1);
        vecs[30] = mk(1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'hC0DE_0003, 32'hF0F0_F0F0, 32'hC0DE_0003, 32'hC0DE_0004, 1'b1);
        vecs[31] = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'hC0DE_0003, 32'hF0F0_F0F0, 32'hC0DE_0003, 32'hF0F0_F0F0, 1'b0);

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", RH, RL, RH, RL, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            drive(vecs[i].st, vecs[i].fe, vecs[i].fm, vecs[i].hwe, vecs[i].lwe, vecs[i].hi, vecs[i].lo);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].xhf, vecs[i].xlf, vecs[i].xha, vecs[i].xla, vecs[i].xp);
        end

        // fill M and W, then assert reset mid-cycle
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3333_3333, 32'h4444_4444);
        @(posedge clk);
        #1;
        chk("pre-reset pending", {31'd0, pending}, 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async reset", RH, RL, RH, RL, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("post reset", RH, RL, RH, RL, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
